// File: rtl/muldiv_sequencer.sv
// Iterative MIPS mult/multu/div/divu sequencer owning HI/LO and the pipeline stall hook.
// Optional macro MULDIV_EARLY_OUT_EN lets MUL finish as soon as the remaining multiplier is zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_lo_read,
  input  logic             hi_lo_write,
  input  logic             hi_lo_sel,
  input  logic [WIDTH-1:0] hi_lo_write_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    SIGN = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [5:0]         count;
  logic               neg_lo;
  logic               neg_hi;
  logic               is_div;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hi_lo_read | hi_lo_write);

  // Operand decode: op[0]=1 is the unsigned flavour, op[1]=1 is divide.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & operand_a[WIDTH-1];
    b_neg     = is_signed & operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
    div_zero  = op[1] & (operand_b == '0);
  end

  // One shift-add step and one restoring-divide step; the trial subtract
  // includes the bit shifted out of the remainder so 2*rem+1 never overflows.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    div_top   = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_top - {1'b0, mcand};
  end

  // After an early exit the partial product still sits high in the
  // accumulator; shift it down by the iterations that were skipped.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    product = acc >> (6'(WIDTH) - count);
`else
    product = acc;
`endif
    product_fix = neg_lo ? -product : product;
    quot_fix    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !div_zero) begin
          state_next = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (count == 6'(WIDTH - 1)) begin
          state_next = SIGN;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if ((mplier >> 1) == '0) begin
          state_next = SIGN;
        end
`endif
      end
      DIV: begin
        if (count == 6'(WIDTH - 1)) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and HI/LO ownership. An IDLE HI/LO write commits at once even
  // alongside a start; the muldiv result overwrites it later at SIGN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      is_div      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_lo_write) begin
            if (hi_lo_sel) begin
              hi <= hi_lo_write_data;
            end else begin
              lo <= hi_lo_write_data;
            end
          end
          if (start) begin
            if (div_zero) begin
              div_by_zero <= 1'b1;
            end else begin
              is_div <= op[1];
              count  <= '0;
              mplier <= b_mag;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
              if (op[1]) begin
                mcand <= b_mag;
                acc   <= {{WIDTH{1'b0}}, a_mag};
              end else begin
                mcand <= a_mag;
                acc   <= '0;
              end
            end
          end
        end
        MUL: begin
          acc    <= {mul_sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
        end
        DIV: begin
          acc   <= {(div_trial[WIDTH] ? div_top[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                    acc[WIDTH-2:0], ~div_trial[WIDTH]};
          count <= count + 6'd1;
        end
        SIGN: begin
          if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            hi <= product_fix[2*WIDTH-1:WIDTH];
            lo <= product_fix[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN when computing expected multiply latency.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_lo_read;
  logic        hi_lo_write;
  logic        hi_lo_sel;
  logic [31:0] hi_lo_write_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .hi_lo_read(hi_lo_read),
    .hi_lo_write(hi_lo_write),
    .hi_lo_sel(hi_lo_sel),
    .hi_lo_write_data(hi_lo_write_data),
    .busy(busy),
    .stall(stall),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference results straight from MIPS arithmetic rules.
  task automatic modelOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    int sa, sb;
    case (o)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        exp_hi = sp[63:32];
        exp_lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000;
          exp_hi = 32'd0;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          exp_lo = 32'(sa / sb);
          exp_hi = 32'(sa % sb);
        end
      end
      default: begin
        if (b != 32'd0) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
    endcase
  endtask

  // Edges from the start edge until done is seen.
  function automatic int expLatency(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mag;
    int top;
    if (!o[1]) begin
      mag = (!o[0] && b[31]) ? -b : b;
      top = 0;
      for (int i = 0; i < 32; i++) begin
        if (mag[i]) top = i;
      end
      return top + 2;
    end
`endif
    return 33;
  endfunction

  // probe: 0 none, 1 mfhi from cycle 4, 2 mthi during busy, 3 mtlo in start cycle
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int probe);
    int n;
    int lat;
    logic [31:0] old_hi;
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    if (probe == 3) begin
      hi_lo_write = 1'b1;
      hi_lo_sel = 1'b0;
      hi_lo_write_data = 32'h5555_AAAA;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_lo_write = 1'b0;
    if (probe == 3) begin
      checkOutput("same_cycle_mtlo", lo, 32'h5555_AAAA);
    end
    if (o[1] && b == 32'd0) begin
      checkOutput("dbz_pulse", div_by_zero, 1'b1);
      checkOutput("dbz_busy", busy, 1'b0);
      checkOutput("dbz_hi", hi, exp_hi);
      checkOutput("dbz_lo", lo, exp_lo);
      @(posedge clk);
      #1;
      checkOutput("dbz_clear", div_by_zero, 1'b0);
      return;
    end
    checkOutput("busy_after_e0", busy, 1'b1);
    old_hi = hi;
    n = 0;
    while (n < 100) begin
      if (probe == 1 && n == 4) begin
        hi_lo_read = 1'b1;
        #1;
        checkOutput("stall_mfhi", stall, 1'b1);
      end
      if (probe == 2 && n == 4) begin
        hi_lo_write = 1'b1;
        hi_lo_sel = 1'b1;
        hi_lo_write_data = 32'hDEAD_BEEF;
        #1;
        checkOutput("stall_mthi", stall, 1'b1);
      end
      @(posedge clk);
      #1;
      n++;
      if (probe == 2 && n == 5) begin
        hi_lo_write = 1'b0;
        checkOutput("mthi_blocked", hi, old_hi);
      end
      if (done) break;
    end
    lat = expLatency(o, b);
    modelOp(o, a, b);
    checkOutput("latency", n, lat);
    checkOutput("busy_at_done", busy, 1'b0);
    if (probe == 1) begin
      checkOutput("stall_drop", stall, 1'b0);
      hi_lo_read = 1'b0;
    end
    checkOutput("hi", hi, exp_hi);
    checkOutput("lo", lo, exp_lo);
    @(posedge clk);
    #1;
    checkOutput("done_pulse", done, 1'b0);
  endtask

  task automatic idleWrite(input logic sel, input logic [31:0] data);
    @(negedge clk);
    hi_lo_write = 1'b1;
    hi_lo_sel = sel;
    hi_lo_write_data = data;
    @(posedge clk);
    #1;
    hi_lo_write = 1'b0;
    if (sel) exp_hi = data;
    else exp_lo = data;
    checkOutput(sel ? "mthi_idle" : "mtlo_idle", sel ? hi : lo, data);
  endtask

  initial begin
    int seen_done;
    logic [1:0] r_op;
    logic [31:0] r_a, r_b;
    checks = 0;
    failures = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    operand_a = 32'd0;
    operand_b = 32'd0;
    hi_lo_read = 1'b0;
    hi_lo_write = 1'b0;
    hi_lo_sel = 1'b0;
    hi_lo_write_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2'b01, 32'd7, 32'd6, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'd16, 0);
    idleWrite(1'b1, 32'h11);
    idleWrite(1'b0, 32'h22);
    applyStimulus(2'b11, 32'd5, 32'd0, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(2'b00, 32'd1234, 32'hFFFF_FF00, 1);
    applyStimulus(2'b01, 32'hCAFE_0001, 32'h0000_0101, 2);
    applyStimulus(2'b11, 32'd1000, 32'd7, 3);
    applyStimulus(2'b01, 32'd9, 32'd3, 0);
    applyStimulus(2'b01, 32'd9, 32'd0, 0);

    // Reset in the middle of a divide discards the result.
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    operand_a = 32'd100;
    operand_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    checkOutput("midreset_busy", busy, 1'b0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    checkOutput("midreset_no_done", seen_done, 0);

    for (int k = 0; k < 24; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      case ($urandom_range(0, 4))
        0: r_b = 32'($urandom_range(0, 15));
        1: r_b = 32'd0;
        2: r_b = 32'd1 << $urandom_range(0, 31);
        3: r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        idleWrite(1'($urandom_range(0, 1)), $urandom);
      end
      applyStimulus(r_op, r_a, r_b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
